// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative shift-add multiplier for the CPU execute stage.
// Computes the full 2*WIDTH-bit product of two WIDTH-bit operands, either
// unsigned or two's-complement, one multiplier bit per clock.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      request, sampled only while busy=0
//   op_signed  1 = signed operands, sampled with start
//   a, b       multiplicand / multiplier, sampled with start
//   busy       operation in progress (the CPU stalls on this)
//   done       one-cycle pulse: result/result_hi/carry are valid
//   result     product bits [WIDTH-1:0]
//   result_hi  product bits [2*WIDTH-1:WIDTH]
//   carry      product does not fit in WIDTH bits (signed or unsigned sense)
//
// Timing: with k multiplier iterations (WIDTH, or the significant bit count of
// |b| when EARLY_EXIT=1), done rises k+2 edges after the edge that took start.
module seq_mult_unit #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q, acc_d;        // upper half of the product
    logic [WIDTH-1:0] mplier_q, mplier_d;  // multiplier, fills with low product bits
    logic             sign_q, sign_d;
    logic             op_signed_q, op_signed_d;
    logic [CW-1:0]    k_q, k_d;            // number of RUN iterations for this op
    logic [CW-1:0]    cnt_q, cnt_d;        // RUN iterations remaining
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             carry_q, carry_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [CW-1:0]      k_calc;
    logic [CW-1:0]      shamt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        // Magnitudes: |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is correct
        // when read back as an unsigned WIDTH-bit value.
        a_abs = (op_signed && a[WIDTH-1]) ? -a : a;
        b_abs = (op_signed && b[WIDTH-1]) ? -b : b;

        k_calc = CW'(WIDTH);
        if (EARLY_EXIT) begin
            k_calc = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (b_abs[i]) k_calc = CW'(i + 1);
            end
        end

        // One iteration: conditional add with the carry kept in bit WIDTH.
        sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

        // Early exit leaves the partial product scaled by 2^(WIDTH-k); the
        // skipped iterations would only have shifted zeros in.
        shamt = CW'(WIDTH) - k_q;
        prod  = {acc_q, mplier_q} >> shamt;
        if (sign_q) prod = -prod;
    end

    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        sign_d      = sign_q;
        op_signed_d = op_signed_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d     = a_abs;
                    mplier_d    = b_abs;
                    acc_d       = '0;
                    sign_d      = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    op_signed_d = op_signed;
                    k_d         = k_calc;
                    cnt_d       = k_calc;
                    state_d     = (k_calc == '0) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                {acc_d, mplier_d} = prod;
                state_d           = S_DONE;
            end
            S_DONE: begin
                result_d    = mplier_q;
                result_hi_d = acc_q;
                carry_d     = op_signed_q ? (acc_q != {WIDTH{mplier_q[WIDTH-1]}})
                                          : (acc_q != '0);
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            sign_q      <= 1'b0;
            op_signed_q <= 1'b0;
            k_q         <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            sign_q      <= sign_d;
            op_signed_q <= op_signed_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit (WIDTH=32). Instance u_full runs every iteration,
// instance u_early has EARLY_EXIT=1. Both share clock, reset and operands.
module tb_seq_mult_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start0, start1;
    logic        op_signed;
    logic [31:0] a, b;

    logic        busy0, done0, carry0;
    logic [31:0] result0, result_hi0;
    logic        busy1, done1, carry1;
    logic [31:0] result1, result_hi1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_unit #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .resetn(resetn), .start(start0), .op_signed(op_signed),
        .a(a), .b(b), .busy(busy0), .done(done0),
        .result(result0), .result_hi(result_hi0), .carry(carry0)
    );

    seq_mult_unit #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_early (
        .clk(clk), .resetn(resetn), .start(start1), .op_signed(op_signed),
        .a(a), .b(b), .busy(busy1), .done(done1),
        .result(result1), .result_hi(result_hi1), .carry(carry1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        logic [63:0] xe, ye;
        xe = s ? {{32{x[31]}}, x} : {32'd0, x};
        ye = s ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;  // low 64 bits are exact in both modes
    endfunction

    function automatic logic ref_carry(input logic [63:0] p, input logic s);
        longint sp;
        sp = longint'(p);
        if (s) return (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
        return p[63:32] != 32'd0;
    endfunction

    function automatic int ref_lat(input int sel, input logic [31:0] y, input logic s);
        logic [31:0] mag;
        mag = (s && y[31]) ? -y : y;
        if (sel == 0) return 32 + 2;
        if (mag == 32'd0) return 2;
        return $clog2(longint'(mag) + 1) + 2;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    function automatic logic [64:0] outs_of(input int sel);
        return (sel == 0) ? {carry0, result_hi0, result0} : {carry1, result_hi1, result1};
    endfunction

    // One op with explicit expectations. Entered and left at posedge+1.
    task automatic run_op(input int sel, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic ts, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_c, input int exp_lat, input string tag);
        int n;
        a = ta; b = tbv; op_signed = ts;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        check({tag, " busy_rise"}, 64'(busy_of(sel)), 64'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done_of(sel) && n < 100);
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " outputs"}, 64'(outs_of(sel) >> 32), {31'd0, exp_c, exp_hi});
        check({tag, " result"}, 64'(outs_of(sel) & 65'hFFFF_FFFF), {32'd0, exp_lo});
        check({tag, " busy_at_done"}, 64'(busy_of(sel)), 64'd0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(done_of(sel)), 64'd0);
    endtask

    task automatic run_rand(input int sel, input logic [31:0] ta, input logic [31:0] tbv,
                            input logic ts, input string tag);
        logic [63:0] p;
        p = ref_prod(ta, tbv, ts);
        run_op(sel, ta, tbv, ts, p[63:32], p[31:0], ref_carry(p, ts),
               ref_lat(sel, tbv, ts), tag);
    endtask

    initial begin
        int n, dcount, t_first, t_second;
        logic busy_ok;
        logic [31:0] ra, rb;
        logic rs;

        resetn = 1'b0; start0 = 1'b0; start1 = 1'b0;
        op_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_full", 64'({busy0, done0, outs_of(0)}), 64'd0);
        check("reset_early", 64'({busy1, done1, outs_of(1)}), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed products with known answers.
        run_op(0, 32'd13, 32'd15, 1'b0, 32'h0, 32'h0000_00C3, 1'b0, 34, "u13x15");
        run_op(0, 32'hFFFF_FFFF, 32'd13, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF3, 1'b0, 34, "s_m1x13");
        run_op(0, 32'hFFFF_FFFF, 32'd13, 1'b0, 32'h0000_000C, 32'hFFFF_FFF3, 1'b1, 34, "u_ffx13");
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1, 1'b1, 34, "u_max");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 1'b1, 34, "s_min");

        // Second start 5 cycles into an op is ignored.
        a = 32'd13; b = 32'd15; op_signed = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; busy_ok = busy0; n = 0;
        repeat (4) begin
            @(posedge clk); #1; n++; busy_ok &= busy0;
        end
        a = 32'd7; b = 32'd9; start0 = 1'b1;
        @(posedge clk); #1;
        n++; start0 = 1'b0; busy_ok &= busy0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!done0) busy_ok &= busy0;
        end while (!done0 && n < 100);
        check("ignore_start latency", 64'(n), 64'd34);
        check("ignore_start result", 64'({result_hi0, result0}), 64'd195);
        check("ignore_start busy_held", 64'(busy_ok), 64'd1);
        dcount = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done0 || busy0) dcount++;
        end
        check("ignore_start no_second_op", 64'(dcount), 64'd0);

        // Reset mid-RUN aborts with outputs cleared at once.
        a = 32'd100; b = 32'd200; op_signed = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("abort outputs", 64'({busy0, done0, outs_of(0)}), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        dcount = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done0) dcount++;
        end
        check("abort no_done", 64'(dcount), 64'd0);
        run_rand(0, 32'd100, 32'd200, 1'b0, "after_abort");

        // Early exit latencies.
        run_op(1, 32'd5, 32'd0, 1'b0, 32'h0, 32'h0, 1'b0, 2, "ee_b0");
        run_op(1, 32'd13, 32'd15, 1'b0, 32'h0, 32'd195, 1'b0, 6, "ee_13x15");
        run_rand(1, 32'hFFFF_FFF3, 32'hFFFF_FFF1, 1'b1, "ee_neg");

        // Start held high: DONE-cycle start ignored, next op taken k+3 later.
        a = 32'd13; b = 32'd15; op_signed = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        n = 0; t_first = -1; t_second = -1;
        repeat (20) begin
            @(posedge clk); #1;
            n++;
            if (done1) begin
                if (t_first < 0) t_first = n;
                else if (t_second < 0) t_second = n;
            end
        end
        start1 = 1'b0;
        check("b2b first_done", 64'(t_first), 64'd6);
        check("b2b second_done", 64'(t_second), 64'd13);
        repeat (10) @(posedge clk);
        #1;

        // Random sweep on both instances.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb = rb >> $urandom_range(31, 0);
            if (i % 5 == 0) ra = ra >> $urandom_range(31, 0);
            rs = 1'($urandom_range(1, 0));
            run_rand(i % 2, ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
